// File: rtl/sr_cmd_driver.sv
// sr_cmd_driver
//   Upstream driver for an SR latch. Two raw, asynchronous and possibly bouncy request lines
//   are synchronised, debounced and edge-detected. The rising edges are then arbitrated into
//   clean, fixed-width s/r pulses that are never high together. After each pulse the latch
//   q/qbar readback is checked during a one-cycle gap.
//
// Parameters
//   DebCycles  consecutive stable synced cycles before a debounced level flips (>= 1)
//   PulseLen   cycles s or r is held high per command (>= 1)
//   CntW       width of the saturating conflict counter
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           synchronous active-high reset
//   set_req_i       raw set request (async, may bounce)
//   rst_req_i       raw reset request (async, may bounce)
//   q_i, qbar_i     latch feedback
//   s_o, r_o        latch S / R drive
//   busy_o          high while the FSM is not idle
//   conflict_o      one-cycle pulse when set and reset edges land in the same cycle
//   conflict_cnt_o  saturating count of conflict events
//   chk_err_o       sticky latch readback mismatch flag
module sr_cmd_driver #(
    parameter int unsigned DebCycles = 4,
    parameter int unsigned PulseLen  = 3,
    parameter int unsigned CntW      = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            set_req_i,
    input  logic            rst_req_i,
    input  logic            q_i,
    input  logic            qbar_i,
    output logic            s_o,
    output logic            r_o,
    output logic            busy_o,
    output logic            conflict_o,
    output logic [CntW-1:0] conflict_cnt_o,
    output logic            chk_err_o
);

    localparam int unsigned DebW = $clog2(DebCycles + 1);
    localparam int unsigned PlsW = (PulseLen > 1) ? $clog2(PulseLen) : 1;

    typedef enum logic [1:0] {StIdle, StPulseS, StPulseR, StGap} state_e;
    typedef enum logic [1:0] {CmdNone, CmdSet, CmdRst} cmd_e;

    // Front end, bit 0 = set line, bit 1 = reset line.
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      deb_q;
    logic [1:0]      deb_prev_q;
    logic [1:0]      rise_q;
    logic [DebW-1:0] deb_cnt_q [2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_prev_q   <= '0;
            rise_q       <= '0;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
        end else begin
            sync1_q    <= {rst_req_i, set_req_i};
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            // Edge pulse is registered so the FSM only ever sees flop outputs.
            rise_q     <= deb_q & ~deb_prev_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DebW'(DebCycles - 1)) begin
                    deb_q[i]     <= ~deb_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DebW'(1);
                end
            end
        end
    end

    logic both_rise;
    assign both_rise = &rise_q;

    // Arbitration FSM.
    state_e          state_q;
    cmd_e            active_q;
    cmd_e            pending_q;
    cmd_e            pend_eff;
    logic [PlsW-1:0] pls_cnt_q;
    logic            s_q;
    logic            r_q;
    logic            busy_q;
    logic            conflict_q;
    logic [CntW-1:0] conflict_cnt_q;
    logic            chk_err_q;

    // Pending slot including a request arriving this cycle; a lone opposite edge overwrites,
    // a same-command edge is merged away, simultaneous edges leave the slot alone.
    always_comb begin
        pend_eff = pending_q;
        if (rise_q == 2'b10 && active_q == CmdSet) begin
            pend_eff = CmdRst;
        end else if (rise_q == 2'b01 && active_q == CmdRst) begin
            pend_eff = CmdSet;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            active_q       <= CmdNone;
            pending_q      <= CmdNone;
            pls_cnt_q      <= '0;
            s_q            <= 1'b0;
            r_q            <= 1'b0;
            busy_q         <= 1'b0;
            conflict_q     <= 1'b0;
            conflict_cnt_q <= '0;
            chk_err_q      <= 1'b0;
        end else begin
            conflict_q <= both_rise;
            if (both_rise && conflict_cnt_q != '1) begin
                conflict_cnt_q <= conflict_cnt_q + CntW'(1);
            end

            unique case (state_q)
                StIdle: begin
                    pls_cnt_q <= '0;
                    if (rise_q == 2'b01) begin
                        state_q  <= StPulseS;
                        active_q <= CmdSet;
                        s_q      <= 1'b1;
                        busy_q   <= 1'b1;
                    end else if (rise_q == 2'b10) begin
                        state_q  <= StPulseR;
                        active_q <= CmdRst;
                        r_q      <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end

                StPulseS, StPulseR: begin
                    pending_q <= pend_eff;
                    if (pls_cnt_q == PlsW'(PulseLen - 1)) begin
                        state_q <= StGap;
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                    end else begin
                        pls_cnt_q <= pls_cnt_q + PlsW'(1);
                    end
                end

                StGap: begin
                    // Latch has had the whole pulse to settle; compare against the command.
                    if (active_q == CmdSet && !(q_i && !qbar_i)) begin
                        chk_err_q <= 1'b1;
                    end
                    if (active_q == CmdRst && !(!q_i && qbar_i)) begin
                        chk_err_q <= 1'b1;
                    end
                    pending_q <= CmdNone;
                    pls_cnt_q <= '0;
                    case (pend_eff)
                        CmdSet: begin
                            state_q  <= StPulseS;
                            active_q <= CmdSet;
                            s_q      <= 1'b1;
                        end
                        CmdRst: begin
                            state_q  <= StPulseR;
                            active_q <= CmdRst;
                            r_q      <= 1'b1;
                        end
                        default: begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end

                default: begin
                    state_q <= StIdle;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_o            = s_q;
    assign r_o            = r_q;
    assign busy_o         = busy_q;
    assign conflict_o     = conflict_q;
    assign conflict_cnt_o = conflict_cnt_q;
    assign chk_err_o      = chk_err_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// tb_sr_cmd_driver
//   Self-checking bench for sr_cmd_driver with an SR latch model on q/qbar.
//   Inputs are driven 1 time unit after each rising edge and outputs sampled there too, so
//   row j of a sequence is the state after edge j (edge j being the first to sample row j).
module tb_sr_cmd_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_req;
    logic       rst_req;
    logic       q;
    logic       qbar;
    logic       s;
    logic       r;
    logic       busy;
    logic       conflict;
    logic [7:0] conflict_cnt;
    logic       chk_err;

    logic latch_q  = 1'b0;
    logic force_q0 = 1'b0;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic set_req;
        logic rst_req;
        logic s;
        logic r;
        logic busy;
        logic conflict;
    } vec_t;

    vec_t vecs[$];

    sr_cmd_driver #(
        .DebCycles(4),
        .PulseLen (3),
        .CntW     (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .set_req_i     (set_req),
        .rst_req_i     (rst_req),
        .q_i           (q),
        .qbar_i        (qbar),
        .s_o           (s),
        .r_o           (r),
        .busy_o        (busy),
        .conflict_o    (conflict),
        .conflict_cnt_o(conflict_cnt),
        .chk_err_o     (chk_err)
    );

    always #5 clk = ~clk;

    // SR latch model; force_q0 pulls q low to fake a latch that failed to set.
    always @(posedge clk) begin
        if (s) latch_q <= 1'b1;
        else if (r) latch_q <= 1'b0;
    end
    assign q    = force_q0 ? 1'b0 : latch_q;
    assign qbar = ~latch_q;

    // s and r must never be high together.
    always @(negedge clk) begin
        checks++;
        if (s && r) begin
            failures++;
            $display("FAIL s_and_r: s=%0b r=%0b, required not both high", s, r);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic a, input logic b, input logic es, input logic er,
                       input logic eb, input logic ec);
        vecs.push_back({a, b, es, er, eb, ec});
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Clean set: s high on edges 7..9, gap on 10.
        for (int j = 0; j < 14; j++) add(1'b1, 1'b0, (j >= 7 && j <= 9), 1'b0, (j >= 7 && j <= 10), 1'b0);
        add_idle(10);
        // Bounce 1,0,1,0,1,0 then stable 1 from row 6: s on 13..15.
        for (int j = 0; j < 6; j++) add((j % 2) == 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 6; j < 20; j++) add(1'b1, 1'b0, (j >= 13 && j <= 15), 1'b0, (j >= 13 && j <= 16), 1'b0);
        add_idle(10);
        // Simultaneous set and reset edges: no pulse, conflict once.
        for (int j = 0; j < 10; j++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (j == 7));
        add_idle(10);

        rst     = 1'b1;
        set_req = 1'b0;
        rst_req = 1'b0;
        tick();
        tick();
        chk("reset.s", 8'(s), 8'h0);
        chk("reset.r", 8'(r), 8'h0);
        chk("reset.busy", 8'(busy), 8'h0);
        chk("reset.conflict", 8'(conflict), 8'h0);
        chk("reset.conflict_cnt", conflict_cnt, 8'h0);
        chk("reset.chk_err", 8'(chk_err), 8'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            set_req = vecs[i].set_req;
            rst_req = vecs[i].rst_req;
            tick();
            chk($sformatf("vec[%0d].s", i), 8'(s), 8'(vecs[i].s));
            chk($sformatf("vec[%0d].r", i), 8'(r), 8'(vecs[i].r));
            chk($sformatf("vec[%0d].busy", i), 8'(busy), 8'(vecs[i].busy));
            chk($sformatf("vec[%0d].conflict", i), 8'(conflict), 8'(vecs[i].conflict));
        end
        chk("table.conflict_cnt", conflict_cnt, 8'd1);
        chk("table.chk_err", 8'(chk_err), 8'h0);

        // Reset edge seen during 2nd cycle of PULSE_S: s 7..9, gap 10, r 11..13, gap 14.
        for (int e = 0; e < 18; e++) begin
            set_req = 1'b1;
            rst_req = (e >= 2);
            tick();
            chk($sformatf("queue[%0d].s", e), 8'(s), 8'(e >= 7 && e <= 9));
            chk($sformatf("queue[%0d].r", e), 8'(r), 8'(e >= 11 && e <= 13));
            chk($sformatf("queue[%0d].busy", e), 8'(busy), 8'(e >= 7 && e <= 14));
        end
        chk("queue.chk_err", 8'(chk_err), 8'h0);
        set_req = 1'b0;
        rst_req = 1'b0;
        for (int e = 0; e < 10; e++) tick();

        // q pulled low only during the gap after an s pulse: chk_err from edge 11, sticky.
        for (int e = 0; e < 14; e++) begin
            set_req  = 1'b1;
            force_q0 = (e == 11);
            tick();
            chk($sformatf("readback[%0d].s", e), 8'(s), 8'(e >= 7 && e <= 9));
            chk($sformatf("readback[%0d].chk_err", e), 8'(chk_err), 8'(e >= 11));
        end
        force_q0 = 1'b0;
        set_req  = 1'b0;
        for (int e = 0; e < 10; e++) tick();
        chk("readback.sticky", 8'(chk_err), 8'h1);

        // Reset during PULSE_R with a set pending (set edge seen at edge 8).
        for (int e = 0; e < 9; e++) begin
            rst_req = 1'b1;
            set_req = (e >= 1);
            tick();
            chk($sformatf("midrst[%0d].r", e), 8'(r), 8'(e >= 7));
            chk($sformatf("midrst[%0d].s", e), 8'(s), 8'h0);
            chk($sformatf("midrst[%0d].busy", e), 8'(busy), 8'(e >= 7));
        end
        chk("midrst.chk_err_before", 8'(chk_err), 8'h1);
        rst     = 1'b1;
        set_req = 1'b0;
        rst_req = 1'b0;
        tick();
        chk("midrst.r", 8'(r), 8'h0);
        chk("midrst.s", 8'(s), 8'h0);
        chk("midrst.busy", 8'(busy), 8'h0);
        chk("midrst.conflict_cnt", conflict_cnt, 8'h0);
        chk("midrst.chk_err", 8'(chk_err), 8'h0);
        rst = 1'b0;
        for (int e = 0; e < 15; e++) begin
            tick();
            chk($sformatf("after_rst[%0d].s", e), 8'(s), 8'h0);
            chk($sformatf("after_rst[%0d].r", e), 8'(r), 8'h0);
            chk($sformatf("after_rst[%0d].busy", e), 8'(busy), 8'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
